// File: rtl/glyph_band_decoder.sv
// Band-oriented 3x3 glyph decoder: fetches three row words per glyph from the
// image SRAM, decodes them to an 8-bit code and hands it out over valid/ready.
module glyph_band_decoder #(
  parameter int SRAM_DATA_WIDTH = 4,
  parameter int SRAM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH      = 8,
  parameter int ROW_STRIDE      = 40,
  parameter int SRAM_LATENCY    = 1,
  parameter int BAND_WIDTH      = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DATA_WIDTH-1:0]      width,
  input  logic [BAND_WIDTH-1:0]      bands,
  input  logic [SRAM_DATA_WIDTH-1:0] SRAM_data,
  input  logic                       out_ready,
  output logic                       SRAM_enable,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_addr,
  output logic                       valid,
  output logic [DATA_WIDTH-1:0]      out,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = SRAM_ADDR_WIDTH + BAND_WIDTH + 2;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, FIN} state_t;

  state_t                state_q, state_d;
  logic [1:0]            fetchIdx_q, fetchIdx_d;
  logic [1:0]            waitCnt_q, waitCnt_d;
  logic [DATA_WIDTH-1:0] col_q, col_d;
  logic [DATA_WIDTH-1:0] width_q, width_d;
  logic [BAND_WIDTH-1:0] band_q, band_d;
  logic [BAND_WIDTH-1:0] bands_q, bands_d;
  logic [2:0][2:0]       pix_q;

  // Read-return pipeline: entry 0 of the _d view is the read landing this cycle.
  logic [SRAM_LATENCY-1:0]      pipeValid_q;
  logic [SRAM_LATENCY:0]        pipeValid_d;
  logic [SRAM_LATENCY-1:0][1:0] pipeRow_q;
  logic [SRAM_LATENCY:0][1:0]   pipeRow_d;

  logic            fetchEn;
  logic            waitLast;
  logic [AW-1:0]   addrFull;
  logic [7:0]      code;

  assign fetchEn     = (state_q == FETCH);
  assign waitLast    = (waitCnt_q == 2'(SRAM_LATENCY - 1));
  assign pipeValid_d = {fetchEn, pipeValid_q};
  assign pipeRow_d   = {fetchIdx_q, pipeRow_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetchIdx_q <= '0;
      waitCnt_q  <= '0;
      col_q      <= '0;
      width_q    <= '0;
      band_q     <= '0;
      bands_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetchIdx_q <= fetchIdx_d;
      waitCnt_q  <= waitCnt_d;
      col_q      <= col_d;
      width_q    <= width_d;
      band_q     <= band_d;
      bands_q    <= bands_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipeValid_q <= '0;
      pipeRow_q   <= '0;
      pix_q       <= '0;
    end else begin
      pipeValid_q <= pipeValid_d[SRAM_LATENCY:1];
      pipeRow_q   <= pipeRow_d[SRAM_LATENCY:1];
      if (pipeValid_d[0]) begin
        pix_q[pipeRow_d[0]] <= SRAM_data[2:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fetchIdx_d = fetchIdx_q;
    waitCnt_d  = waitCnt_q;
    col_d      = col_q;
    width_d    = width_q;
    band_d     = band_q;
    bands_d    = bands_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          width_d    = width;
          bands_d    = bands;
          col_d      = '0;
          band_d     = '0;
          fetchIdx_d = '0;
          waitCnt_d  = '0;
          state_d    = (width == '0 || bands == '0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        if (fetchIdx_q == 2'd2) begin
          fetchIdx_d = '0;
          waitCnt_d  = '0;
          state_d    = WAIT;
        end else begin
          fetchIdx_d = fetchIdx_q + 2'd1;
        end
      end
      WAIT: begin
        if (waitLast) begin
          state_d = EMIT;
        end else begin
          waitCnt_d = waitCnt_q + 2'd1;
        end
      end
      EMIT: begin
        // Columns advance fastest, then bands; the last glyph ends the job.
        if (out_ready) begin
          if (col_q != width_q - DATA_WIDTH'(1)) begin
            col_d   = col_q + DATA_WIDTH'(1);
            state_d = FETCH;
          end else begin
            col_d = '0;
            if (band_q != bands_q - BAND_WIDTH'(1)) begin
              band_d  = band_q + BAND_WIDTH'(1);
              state_d = FETCH;
            end else begin
              state_d = FIN;
            end
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addrFull = AW'(band_q) * AW'(3 * ROW_STRIDE)
             + AW'(fetchIdx_q) * AW'(ROW_STRIDE)
             + AW'(col_q);
  end

  // Top-left pixel selects row-major or column-major bit ordering.
  always_comb begin
    if (pix_q[0][0]) begin
      code = {pix_q[1][0], pix_q[2][0], pix_q[0][1], pix_q[1][1],
              pix_q[2][1], pix_q[0][2], pix_q[1][2], pix_q[2][2]};
    end else begin
      code = {pix_q[0][1], pix_q[0][2], pix_q[1][0], pix_q[1][1],
              pix_q[1][2], pix_q[2][0], pix_q[2][1], pix_q[2][2]};
    end
  end

  assign SRAM_enable = fetchEn;
  assign SRAM_addr   = fetchEn ? addrFull[SRAM_ADDR_WIDTH-1:0] : '0;
  assign valid       = (state_q == EMIT);
  assign out         = valid ? DATA_WIDTH'(code) : '0;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);

  generate
    if (SRAM_DATA_WIDTH > 3) begin : gHighBits
      logic unusedHigh;
      assign unusedHigh = ^SRAM_data[SRAM_DATA_WIDTH-1:3];
    end
  endgenerate

endmodule
